// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
//   rf_state_e      : two-state controller (CLEAR sweep, RUN)
//   XLEN, NREGS     : default data width and register count
//   port_lsb()      : bit offset of port i inside a packed multi-port bus
//   idx_in_range()  : true when a register index addresses a real entry
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Port i of a packed bus with field width w starts at bit i*w.
    function automatic int port_lsb(input int i, input int w);
        return i * w;
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file.
//   CLK, RST : clock, synchronous active-high reset (data returns to 0)
//   run      : controller is in RUN; outside RUN the port outputs 0
//   addr     : read index sampled at each edge
//   entry    : current storage content at addr (pre-edge value)
//   wr_fire  : an effective (non-suppressed) write happens at this edge
//   wr_reg   : index of that write
//   wr_data  : data of that write
//   data     : registered read result, one cycle after addr
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] entry,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] data_nxt;

    // Priority: zero register, then out-of-range, then write-first bypass,
    // then stored content.
    always_comb begin
        data_nxt = entry;
        if (!run) begin
            data_nxt = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            data_nxt = '0;
        end else if (!idx_in_range(32'(addr), DEPTH)) begin
            data_nxt = '0;
        end else if ((BYPASS != 0) && wr_fire && (wr_reg == addr)) begin
            data_nxt = wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data <= '0;
        end else begin
            data <= data_nxt;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised integer register file with NUM_RD registered read ports,
// one write port, optional hardwired zero register, optional write-first
// bypass and a post-reset clear sweep.
//   CLK, RST    : clock, synchronous active-high reset
//   READ_ADDR   : packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   READ_DATA   : packed registered read data, port i at [i*DATA_W +: DATA_W]
//   WRITE       : write enable
//   WRITE_REG   : write index
//   WRITE_DATA  : write data
//   READY       : high once the clear sweep has finished
//   DBG_STATE   : current controller state
//
// READY is a level status, not a handshake: while it is low the write port
// is ignored and every READ_DATA is 0; once high, every edge re-samples
// READ_ADDR and commits a write when WRITE is high.
module regfile_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] READ_ADDR,
    output logic [NUM_RD*DATA_W-1:0] READ_DATA,
    input  logic                     WRITE,
    input  logic [ADDR_W-1:0]        WRITE_REG,
    input  logic [DATA_W-1:0]        WRITE_DATA,
    output logic                     READY,
    output rf_state_e                DBG_STATE
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic              run;
    logic              wr_en;

    // ---------------- controller: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // ---------------- controller: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // ---------------- controller: outputs ----------------
    always_comb begin
        run       = (state == RUN);
        READY     = run;
        DBG_STATE = state;
    end

    // A write commits only in RUN, in range, and not to a hardwired r0.
    always_comb begin
        wr_en = run && WRITE && idx_in_range(32'(WRITE_REG), DEPTH);
        if ((ZERO_REG != 0) && (WRITE_REG == '0)) begin
            wr_en = 1'b0;
        end
    end

    // Storage has no reset; the sweep is its only initialisation path.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == CLEAR) begin
                mem[clr_idx[IDX_W-1:0]] <= '0;
            end else if (wr_en) begin
                mem[WRITE_REG[IDX_W-1:0]] <= WRITE_DATA;
            end
        end
    end

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] entry;

        assign addr  = READ_ADDR[port_lsb(i, ADDR_W) +: ADDR_W];
        // Out-of-range indices are masked to 0 inside the port, so the
        // truncated lookup here never reaches READ_DATA for them.
        assign entry = mem[addr[IDX_W-1:0]];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .CLK     (CLK),
            .RST     (RST),
            .run     (run),
            .addr    (addr),
            .entry   (entry),
            .wr_fire (wr_en),
            .wr_reg  (WRITE_REG),
            .wr_data (WRITE_DATA),
            .data    (READ_DATA[port_lsb(i, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
    import rf_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // dut_a: defaults (ZERO_REG=1, BYPASS=1); dut_b: ZERO_REG=0, BYPASS=0.
    // Both share the same read/write stimulus.
    logic [9:0]  rd_addr = '0;
    logic        wr = 1'b0;
    logic [4:0]  wr_reg = '0;
    logic [31:0] wr_data = '0;
    logic [63:0] rd_data_a, rd_data_b;
    logic        ready_a, ready_b;
    rf_state_e   dbg_a, dbg_b;

    // dut_p: DEPTH=16, NUM_RD=3, DATA_W=64.
    logic [14:0]  rd_addr_p = '0;
    logic         wr_p = 1'b0;
    logic [4:0]   wr_reg_p = '0;
    logic [63:0]  wr_data_p = '0;
    logic [191:0] rd_data_p;
    logic         ready_p;
    rf_state_e    dbg_p;

    regfile_multiport dut_a (
        .CLK(CLK), .RST(RST), .READ_ADDR(rd_addr), .READ_DATA(rd_data_a),
        .WRITE(wr), .WRITE_REG(wr_reg), .WRITE_DATA(wr_data),
        .READY(ready_a), .DBG_STATE(dbg_a)
    );

    regfile_multiport #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .RST(RST), .READ_ADDR(rd_addr), .READ_DATA(rd_data_b),
        .WRITE(wr), .WRITE_REG(wr_reg), .WRITE_DATA(wr_data),
        .READY(ready_b), .DBG_STATE(dbg_b)
    );

    regfile_multiport #(.DATA_W(64), .DEPTH(16), .ADDR_W(5), .NUM_RD(3)) dut_p (
        .CLK(CLK), .RST(RST), .READ_ADDR(rd_addr_p), .READ_DATA(rd_data_p),
        .WRITE(wr_p), .WRITE_REG(wr_reg_p), .WRITE_DATA(wr_data_p),
        .READY(ready_p), .DBG_STATE(dbg_p)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed=%h but scoreboard queue empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic en, input logic [4:0] r, input logic [31:0] d);
        wr = en; wr_reg = r; wr_data = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] v15;
        logic [63:0] v15b;

        // Reset held for 3 edges.
        RST = 1'b1;
        tick();
        expect_val(64'd0); expect_val(64'd0);
        check("rst_ready_a", 64'(ready_a));
        check("rst_data_a", rd_data_a);
        tick();
        tick();
        RST = 1'b0;

        // Sweep timing: READY after edge 32 (dut_a) and edge 16 (dut_p).
        for (int i = 1; i <= 32; i++) begin
            expect_val(64'(i >= 32));
            expect_val(64'(i >= 16));
            tick();
            check($sformatf("sweep_ready_a_e%0d", i), 64'(ready_a));
            check($sformatf("sweep_ready_p_e%0d", i), 64'(ready_p));
        end
        expect_val(64'(RUN));
        check("sweep_state_a", 64'(dbg_a));

        // Cleared contents read as zero on both ports.
        for (int i = 1; i <= 31; i++) begin
            set_rd(5'(i), 5'(32 - i));
            expect_val(64'd0);
            tick();
            check($sformatf("clear_r%0d", i), rd_data_a);
        end

        // Write then read on both ports.
        set_rd(5'd0, 5'd0);
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        set_rd(5'd5, 5'd5);
        expect_val({2{32'hDEADBEEF}});
        expect_val({2{32'hDEADBEEF}});
        tick();
        check("wr_rd_r5_a", rd_data_a);
        check("wr_rd_r5_b", rd_data_b);

        // Zero register: dut_a ignores the write, dut_b stores it.
        set_wr(1'b1, 5'd0, 32'h12345678);
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        set_rd(5'd0, 5'd5);
        expect_val({32'hDEADBEEF, 32'h00000000});
        expect_val({32'hDEADBEEF, 32'h12345678});
        tick();
        check("zero_reg_a", rd_data_a);
        check("zero_reg_b", rd_data_b);

        // Bypass: preload r8=0x11 and r7 with a known old value.
        set_wr(1'b1, 5'd8, 32'h00000011);
        tick();
        set_wr(1'b1, 5'd7, 32'h0BAD0007);
        tick();
        set_wr(1'b1, 5'd7, 32'hA5A5A5A5);
        set_rd(5'd7, 5'd8);
        expect_val({32'h00000011, 32'hA5A5A5A5});
        expect_val({32'h00000011, 32'h0BAD0007});
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        check("bypass_a", rd_data_a);
        check("nobypass_b", rd_data_b);
        expect_val({32'h00000011, 32'hA5A5A5A5});
        expect_val({32'h00000011, 32'hA5A5A5A5});
        tick();
        check("after_bypass_a", rd_data_a);
        check("after_nobypass_b", rd_data_b);

        // Suppressed r0 write is never forwarded on dut_a.
        set_wr(1'b1, 5'd0, 32'hFFFF0000);
        set_rd(5'd0, 5'd0);
        expect_val(64'd0);
        expect_val({2{32'h12345678}});
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        check("r0_no_fwd_a", rd_data_a);
        check("r0_old_b", rd_data_b);

        // Reset mid-operation.
        set_wr(1'b1, 5'd3, 32'h00000055);
        tick();
        set_wr(1'b0, 5'd0, 32'd0);
        set_rd(5'd3, 5'd3);
        expect_val({2{32'h00000055}});
        tick();
        check("r3_loaded", rd_data_a);
        RST = 1'b1;
        set_wr(1'b1, 5'd3, 32'h00000099);
        expect_val(64'd0); expect_val(64'd0);
        tick();
        RST = 1'b0;
        check("midrst_ready", 64'(ready_a));
        check("midrst_data", rd_data_a);
        set_wr(1'b1, 5'd3, 32'h00000077);
        for (int i = 1; i <= 32; i++) begin
            expect_val(64'(i >= 32));
            expect_val(64'd0);
            tick();
            check($sformatf("resweep_ready_e%0d", i), 64'(ready_a));
            check($sformatf("resweep_data_e%0d", i), rd_data_a);
        end
        set_wr(1'b0, 5'd0, 32'd0);
        expect_val(64'd0);
        expect_val(64'd0);
        tick();
        check("r3_after_sweep_a", rd_data_a);
        check("r3_after_sweep_b", rd_data_b);

        // Parameter sweep: DEPTH=16, 3 ports, 64-bit data.
        v15 = {$urandom(), $urandom()};
        wr_p = 1'b1; wr_reg_p = 5'd20; wr_data_p = 64'hCAFEF00D_12345678;
        tick();
        wr_reg_p = 5'd15; wr_data_p = v15;
        tick();
        wr_p = 1'b0;
        rd_addr_p = {5'd16, 5'd15, 5'd20};
        expect_val(64'd0);
        expect_val(v15);
        expect_val(64'd0);
        tick();
        check("p_r20_oor", rd_data_p[63:0]);
        check("p_r15", rd_data_p[127:64]);
        check("p_r16_oor", rd_data_p[191:128]);

        // Bypass on the wide instance: port1 sees the same-edge write.
        v15b = {$urandom(), 32'(($urandom_range(1, 1000)))};
        wr_p = 1'b1; wr_reg_p = 5'd15; wr_data_p = v15b;
        rd_addr_p = {5'd0, 5'd15, 5'd15};
        expect_val(v15b);
        expect_val(v15b);
        tick();
        wr_p = 1'b0;
        check("p_bypass_port0", rd_data_p[63:0]);
        check("p_bypass_port1", rd_data_p[127:64]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
